serial_memory_loader: RTL and testbench

Byte-oriented command engine that sits upstream of `Processor` and drives its external memory port: pause, externalMemoryControl, externalAddress, externalData, externalReadMode, externalWriteMode and externalDataOut. It accepts framed commands from an RS232 receiver byte stream and performs word writes and word reads into processor memory. It halts and releases the processor and returns acknowledge or read data bytes to an RS232 transmitter. It replaces bench-driven loading in hardware.

---
 rtl/serial_memory_loader.sv | 175 +++++++++++++++++
 tb/tb_serial_memory_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_memory_loader.sv
// serial_memory_loader: byte-framed command engine that pauses the processor and
// performs word reads/writes on its external memory port, replying over a byte tx link.
// Optional macro SERIAL_LOADER_TIMEOUT_EN adds an inter-byte timeout in ADDR/DATA.
module serial_memory_loader #(
   parameter int unsigned READ_LATENCY   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        pause,
   output logic        externalMemoryControl,
   output logic [31:0] externalAddress,
   output logic [31:0] externalData,
   output logic [2:0]  externalReadMode,
   output logic [2:0]  externalWriteMode,
   input  logic [31:0] externalDataOut
);

   localparam logic [2:0] MODE_NONE = 3'd0;
   localparam logic [2:0] MODE_WORD = 3'd3;
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_P = 8'h50;
   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   typedef enum logic [2:0] {StIdle, StAddr, StData, StWrite, StRead, StSend, StAck} state_t;

   state_t      state, state_next;
   logic [1:0]  byte_cnt;
   logic [3:0]  lat_cnt;
   logic        is_write;
   logic        reject;
   logic [31:0] rd_shift;
   logic [7:0]  ack_byte;
   logic        rx_fire, tx_fire, timeout, addr_reject;

   assign rx_fire = rx_valid && rx_ready;
   assign tx_fire = tx_valid && tx_ready;
   // Evaluated on the last address byte: misaligned or processor running means no access.
   assign addr_reject = (rx_data[1:0] != 2'b00) || !pause;

`ifdef SERIAL_LOADER_TIMEOUT_EN
   logic [31:0] idle_cycles;
   logic        in_frame;
   assign in_frame = (state == StAddr) || (state == StData);
   assign timeout  = in_frame && !rx_fire && (idle_cycles == 32'(TIMEOUT_CYCLES - 1));

   // Count cycles without an accepted byte while a frame is being assembled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_cycles <= '0;
      else if (in_frame && !rx_fire) idle_cycles <= idle_cycles + 32'd1;
      else idle_cycles <= '0;
   end
`else
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= StIdle;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         StIdle: if (rx_fire) begin
            if (rx_data == CMD_W || rx_data == CMD_R) state_next = StAddr;
            else                                      state_next = StAck;
         end
         StAddr: begin
            if (rx_fire && byte_cnt == 2'd3) begin
               if (is_write)         state_next = StData;
               else if (addr_reject) state_next = StAck;
               else                  state_next = StRead;
            end else if (timeout) state_next = StIdle;
         end
         StData: begin
            if (rx_fire && byte_cnt == 2'd3) state_next = StWrite;
            else if (timeout)                state_next = StIdle;
         end
         StWrite: state_next = StAck;
         StRead:  if (lat_cnt == 4'(READ_LATENCY - 1)) state_next = StSend;
         StSend:  if (tx_fire && byte_cnt == 2'd3) state_next = StIdle;
         StAck:   if (tx_fire) state_next = StIdle;
         default: state_next = StIdle;
      endcase
   end

   // Datapath: frame assembly, processor control, read capture and reply shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pause                 <= 1'b1;
         externalMemoryControl <= 1'b1;
         externalAddress       <= '0;
         externalData          <= '0;
         byte_cnt              <= '0;
         lat_cnt               <= '0;
         is_write              <= 1'b0;
         reject                <= 1'b0;
         rd_shift              <= '0;
         ack_byte              <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               byte_cnt <= '0;
               lat_cnt  <= '0;
               reject   <= 1'b0;
               if (rx_fire) begin
                  is_write <= (rx_data == CMD_W);
                  if (rx_data == CMD_P) begin
                     pause                 <= 1'b1;
                     externalMemoryControl <= 1'b1;
                     ack_byte              <= ACK;
                  end else if (rx_data == CMD_G) begin
                     pause                 <= 1'b0;
                     externalMemoryControl <= 1'b0;
                     ack_byte              <= ACK;
                  end else begin
                     ack_byte <= NAK;
                  end
               end
            end
            StAddr: if (rx_fire) begin
               externalAddress <= {externalAddress[23:0], rx_data};
               byte_cnt        <= byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) begin
                  reject <= addr_reject;
                  if (!is_write) ack_byte <= NAK;
               end
            end
            StData: if (rx_fire) begin
               externalData <= {externalData[23:0], rx_data};
               byte_cnt     <= byte_cnt + 2'd1;
            end
            StWrite: ack_byte <= reject ? NAK : ACK;
            StRead: begin
               lat_cnt <= lat_cnt + 4'd1;
               if (lat_cnt == 4'(READ_LATENCY - 1)) begin
                  rd_shift <= externalDataOut;
                  byte_cnt <= '0;
               end
            end
            StSend: if (tx_fire) begin
               rd_shift <= {rd_shift[23:0], 8'h00};
               byte_cnt <= byte_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; memory modes drop with an asynchronous reset of state.
   always_comb begin
      rx_ready          = (state == StIdle) || (state == StAddr) || (state == StData);
      tx_valid          = (state == StSend) || (state == StAck);
      tx_data           = 8'h00;
      externalWriteMode = MODE_NONE;
      externalReadMode  = MODE_NONE;
      if (state == StSend) tx_data = rd_shift[31:24];
      if (state == StAck)  tx_data = ack_byte;
      if (state == StWrite && !reject && pause) externalWriteMode = MODE_WORD;
      if (state == StRead && pause)             externalReadMode  = MODE_WORD;
   end

endmodule

// File: tb/tb_serial_memory_loader.sv
// Scoreboard bench for serial_memory_loader: expected reply bytes are queued as commands
// are sent and compared as the DUT hands them to the transmitter.
module tb_serial_memory_loader;

   localparam logic [2:0] NONE = 3'd0;
   localparam logic [2:0] WORD = 3'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        pause;
   logic        ext_ctrl;
   logic [31:0] ext_addr;
   logic [31:0] ext_data;
   logic [2:0]  ext_rmode;
   logic [2:0]  ext_wmode;
   logic [31:0] ext_dout;

   logic [31:0] mem [0:1023];
   int vectors = 0;
   int misses  = 0;
   int wr_cycles = 0;
   int rd_cycles = 0;
   int bad_mode  = 0;
   logic [7:0] exp_q [$];

   serial_memory_loader #(.READ_LATENCY(2), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .pause(pause), .externalMemoryControl(ext_ctrl),
      .externalAddress(ext_addr), .externalData(ext_data),
      .externalReadMode(ext_rmode), .externalWriteMode(ext_wmode),
      .externalDataOut(ext_dout)
   );

   always #5 clk = ~clk;

   assign ext_dout = mem[ext_addr[11:2]];

   // Simple word memory standing in for the processor's memory.
   always @(posedge clk) if (ext_wmode == WORD) mem[ext_addr[11:2]] <= ext_data;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         misses++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reply monitor and mode bookkeeping, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (ext_wmode == WORD) wr_cycles++;
         if (ext_rmode == WORD) rd_cycles++;
         if ((ext_wmode == WORD && ext_rmode == WORD) ||
             (!pause && (ext_wmode == WORD || ext_rmode == WORD))) bad_mode++;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check_val("tx_unexpected_qlen", 32'(exp_q.size()), 32'd1);
            else check_val("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check_val("rx_accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
   endtask

   task automatic send_addr(input logic [31:0] a);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
   endtask

   task automatic drain;
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_val("drain_qlen", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic check_read_latency(input logic [7:0] first);
      int n = 0;
      while (ext_rmode == WORD && n < 20) begin
         n++;
         @(posedge clk);
         #1;
      end
      check_val("read_word_cycles", 32'(n), 32'd2);
      check_val("read_tx_valid", {31'h0, tx_valid}, 32'd1);
      check_val("read_first_byte", {24'h0, tx_data}, {24'h0, first});
   endtask

   initial begin
      int w0;
      int r0;
      logic [7:0] d0;
      logic stable;
      int n;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_pause", {31'h0, pause}, 32'd1);
      check_val("rst_ctrl", {31'h0, ext_ctrl}, 32'd1);
      check_val("rst_addr", ext_addr, 32'h0);
      check_val("rst_data", ext_data, 32'h0);
      check_val("rst_modes", {26'h0, ext_rmode, ext_wmode}, 32'h0);
      check_val("rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
      check_val("rst_rx_ready", {31'h0, rx_ready}, 32'd1);
      @(negedge clk) rst = 1'b0;

      // Word write, then its ack one cycle after the single WORD cycle.
      exp_q.push_back(8'h06);
      send_byte(8'h57); send_addr(32'h0000_0400); send_addr(32'h0800_3FFB);
      check_val("wr_mode_word", {29'h0, ext_wmode}, {29'h0, WORD});
      check_val("wr_addr", ext_addr, 32'h0000_0400);
      check_val("wr_data", ext_data, 32'h0800_3FFB);
      @(posedge clk); #1;
      check_val("wr_mode_none", {29'h0, ext_wmode}, {29'h0, NONE});
      check_val("wr_ack_valid", {31'h0, tx_valid}, 32'd1);
      drain();
      check_val("wr_mem", mem[256], 32'h0800_3FFB);
      check_val("wr_cycles", 32'(wr_cycles), 32'd1);

      // Read back.
      push_word(32'h0800_3FFB);
      send_byte(8'h52); send_addr(32'h0000_0400);
      check_read_latency(8'h08);
      drain();

      // Misaligned write is consumed but not performed.
      w0 = wr_cycles;
      exp_q.push_back(8'h15);
      send_byte(8'h57); send_addr(32'h0000_0402); send_addr(32'h1122_3344);
      drain();
      check_val("misaligned_no_write", 32'(wr_cycles), 32'(w0));
      check_val("misaligned_mem", mem[256], 32'h0800_3FFB);

      // Unknown command.
      exp_q.push_back(8'h15);
      send_byte(8'hAA);
      drain();

      // Release processor; reads are then refused.
      exp_q.push_back(8'h06);
      send_byte(8'h47);
      check_val("go_pause", {31'h0, pause}, 32'd0);
      check_val("go_ctrl", {31'h0, ext_ctrl}, 32'd0);
      check_val("go_ack_valid", {31'h0, tx_valid}, 32'd1);
      drain();
      r0 = rd_cycles;
      exp_q.push_back(8'h15);
      send_byte(8'h52); send_addr(32'h0000_FFFC);
      drain();
      check_val("running_no_read", 32'(rd_cycles), 32'(r0));
      exp_q.push_back(8'h06);
      send_byte(8'h50);
      check_val("pause_again", {31'h0, pause}, 32'd1);
      check_val("pause_ctrl", {31'h0, ext_ctrl}, 32'd1);
      drain();

      // Back-pressure on the read reply.
      tx_ready = 1'b0;
      push_word(32'h0800_3FFB);
      send_byte(8'h52); send_addr(32'h0000_0400);
      n = 0;
      while (!tx_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("bp_valid", {31'h0, tx_valid}, 32'd1);
      d0 = tx_data;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (tx_data !== d0 || !tx_valid || rx_ready) stable = 1'b0;
      end
      check_val("bp_stable", {31'h0, stable}, 32'd1);
      check_val("bp_held_byte", {24'h0, d0}, 32'h08);
      check_val("bp_rx_ready", {31'h0, rx_ready}, 32'd0);
      @(posedge clk); #1 tx_ready = 1'b1;
      drain();

      // Reset in the middle of a read frame.
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
      @(negedge clk) rst = 1'b1;
      #1;
      check_val("midrst_pause", {30'h0, pause, ext_ctrl}, 32'd3);
      check_val("midrst_addr", ext_addr, 32'h0);
      check_val("midrst_rx_ready", {31'h0, rx_ready}, 32'd1);
      check_val("midrst_tx_valid", {31'h0, tx_valid}, 32'd0);
      @(negedge clk) rst = 1'b0;
      push_word(32'h0800_3FFB);
      send_byte(8'h52); send_addr(32'h0000_0400);
      check_read_latency(8'h08);
      drain();

`ifdef SERIAL_LOADER_TIMEOUT_EN
      // Abandoned frame times out silently; the next 'P' is decoded as a command.
      w0 = wr_cycles;
      send_byte(8'h57); send_byte(8'h00);
      repeat (25) @(negedge clk);
      check_val("tmo_no_tx", {31'h0, tx_valid}, 32'd0);
      exp_q.push_back(8'h06);
      send_byte(8'h50);
      drain();
      check_val("tmo_no_write", 32'(wr_cycles), 32'(w0));
`endif

      check_val("mode_rules", 32'(bad_mode), 32'd0);
      check_val("final_qlen", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
